// File: rtl/elim_sequencer_if.sv
// elim_sequencer_if: request, board read/write and status bundle for the elimination sequencer
interface elim_sequencer_if #(parameter int COLOR_W = 3);
  logic start;
  logic [3:0] sel_x, sel_y;
  logic [2:0] rd_x, rd_y;
  logic [COLOR_W-1:0] rd_color;
  logic wr_en;
  logic [2:0] wr_x, wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic busy, done;
  logic [6:0] cleared;
  modport master(output start, sel_x, sel_y, rd_color,
                 input rd_x, rd_y, wr_en, wr_x, wr_y, wr_color, busy, done, cleared);
  modport slave(input start, sel_x, sel_y, rd_color,
                output rd_x, rd_y, wr_en, wr_x, wr_y, wr_color, busy, done, cleared);
endinterface

// File: rtl/elim_sequencer.sv
// elim_sequencer: flood-marks a same-colour group, clears it and applies column gravity on an 8x8 board
module elim_sequencer #(
  parameter int MIN_GROUP = 2,
  parameter int COLOR_W = 3
) (
  input logic clk,
  input logic rst,
  elim_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEED, SCAN, CLEAR, GRAV_RD, GRAV_FILL, DONE} state_t;
  state_t state, state_n;
  logic [63:0] mark;
  logic [5:0] pos;
  logic [2:0] cx, cy, col, rx;
  logic [3:0] wp, wp_dn, wpn;
  logic [COLOR_W-1:0] seed;
  logic chg, nb, hit, valid_seed, keep;
  logic [6:0] cnt;
  assign cx = pos[5:3];
  assign cy = pos[2:0];
  assign wp_dn = wp - 4'd1;
  assign keep = bus.rd_color != '0;
  assign wpn = keep ? wp_dn : wp;
  assign valid_seed = !bus.sel_x[3] && !bus.sel_y[3] && keep;
  assign nb = (cx != 3'd0 && mark[pos - 6'd8]) || (cx != 3'd7 && mark[pos + 6'd8]) ||
              (cy != 3'd0 && mark[pos - 6'd1]) || (cy != 3'd7 && mark[pos + 6'd1]);
  assign hit = state == SCAN && bus.rd_color == seed && nb && !mark[pos];
  // group size of the current mark vector
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 64; i++) cnt = cnt + 7'(mark[i]);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state and board port drive
  always_comb begin
    state_n = state;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.rd_x = cx;
    bus.rd_y = cy;
    bus.wr_en = 1'b0;
    bus.wr_x = cx;
    bus.wr_y = cy;
    bus.wr_color = '0;
    case (state)
      IDLE: state_n = bus.start ? SEED : IDLE;
      SEED: begin
        bus.rd_x = bus.sel_x[2:0];
        bus.rd_y = bus.sel_y[2:0];
        state_n = valid_seed ? SCAN : DONE;
      end
      SCAN: state_n = pos != 6'd63 || chg || hit ? SCAN : int'(cnt) < MIN_GROUP ? DONE : CLEAR;
      CLEAR: begin
        bus.wr_en = mark[pos];
        state_n = pos == 6'd63 ? GRAV_RD : CLEAR;
      end
      GRAV_RD: begin
        bus.rd_x = rx;
        bus.rd_y = col;
        bus.wr_en = keep;
        bus.wr_x = wp[2:0];
        bus.wr_y = col;
        bus.wr_color = bus.rd_color;
        state_n = rx != 3'd0 ? GRAV_RD : !wpn[3] ? GRAV_FILL : col == 3'd7 ? DONE : GRAV_RD;
      end
      GRAV_FILL: begin
        bus.wr_en = 1'b1;
        bus.wr_x = wp[2:0];
        bus.wr_y = col;
        state_n = wp != 4'd0 ? GRAV_FILL : col == 3'd7 ? DONE : GRAV_RD;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // marking, cursors, gravity pointers and result count
  always_ff @(posedge clk) begin
    if (rst) begin
      mark <= '0;
      pos <= '0;
      col <= '0;
      rx <= '0;
      wp <= '0;
      seed <= '0;
      chg <= 1'b0;
      bus.cleared <= '0;
    end else begin
      if (state == SEED) begin
        seed <= bus.rd_color;
        mark <= 64'd1 << {bus.sel_x[2:0], bus.sel_y[2:0]};
        chg <= 1'b1;
        pos <= '0;
      end
      if (state == SCAN) begin
        if (hit) mark[pos] <= 1'b1;
        pos <= pos + 6'd1;
        chg <= pos == 6'd63 ? 1'b0 : chg | hit;
      end
      if (state == CLEAR) begin
        pos <= pos + 6'd1;
        col <= '0;
        rx <= 3'd7;
        wp <= 4'd7;
      end
      if (state == GRAV_RD) begin
        rx <= rx - 3'd1;
        wp <= rx == 3'd0 && wpn[3] ? 4'd7 : wpn;
        if (rx == 3'd0 && wpn[3]) col <= col + 3'd1;
      end
      if (state == GRAV_FILL) begin
        wp <= wp == 4'd0 ? 4'd7 : wp_dn;
        if (wp == 4'd0) col <= col + 3'd1;
      end
      if (state_n == DONE && state != DONE)
        bus.cleared <= state == GRAV_RD || state == GRAV_FILL ? cnt : 7'd0;
    end
  end
endmodule

// File: tb/tb_elim_sequencer.sv
// tb_elim_sequencer: directed board scenarios with hand-computed results against a behavioural board
module tb_elim_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  elim_sequencer_if #(.COLOR_W(3)) bus();
  elim_sequencer #(.MIN_GROUP(2), .COLOR_W(3)) dut(.clk(clk), .rst(rst), .bus(bus));
  logic [2:0] board[8][8];
  int errs = 0, checks = 0, wr_seen = 0, done_seen = 0, cyc;
  assign bus.rd_color = board[bus.rd_x][bus.rd_y];
  // board storage and event counters
  always @(posedge clk) begin
    if (bus.wr_en) board[bus.wr_x][bus.wr_y] <= bus.wr_color;
    if (bus.wr_en) wr_seen <= wr_seen + 1;
    if (bus.done) done_seen <= done_seen + 1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic fill(input int v);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) board[i][j] = 3'(v);
  endtask
  function automatic int nz();
    int n = 0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) n += (board[i][j] != 0) ? 1 : 0;
    return n;
  endfunction
  function automatic int colcode(input int c);
    int v = 0;
    for (int i = 0; i < 8; i++) v = v * 8 + int'(board[i][c]);
    return v;
  endfunction
  task automatic kick(input int sx, input int sy);
    wr_seen = 0;
    done_seen = 0;
    bus.sel_x = 4'(sx);
    bus.sel_y = 4'(sy);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 1;
  endtask
  task automatic finish_run(input string tag);
    while (!bus.done && cyc < 5000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, "_done_seen"}, int'(bus.done), 1);
    @(posedge clk);
    #1;
  endtask
  task automatic col0_board();
    fill(0);
    board[0][0] = 3; board[1][0] = 2; board[2][0] = 2;
    for (int i = 3; i < 8; i++) board[i][0] = 1;
  endtask
  initial begin
    bus.start = 1'b1;
    bus.sel_x = 4'd3;
    bus.sel_y = 4'd3;
    fill(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_cleared", int'(bus.cleared), 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 chk("idle_after_rst", int'(bus.busy), 0);
    kick(2, 2);
    finish_run("empty");
    chk("empty_cycles", cyc, 2);
    chk("empty_cleared", int'(bus.cleared), 0);
    chk("empty_writes", wr_seen, 0);
    board[4][4] = 2;
    kick(4, 4);
    finish_run("iso");
    chk("iso_cycles", cyc, 130);
    chk("iso_cleared", int'(bus.cleared), 0);
    chk("iso_writes", wr_seen, 0);
    chk("iso_cell", int'(board[4][4]), 2);
    col0_board();
    kick(1, 0);
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc += 6;
    finish_run("col0");
    chk("col0_cycles", cyc, 316);
    chk("col0_cleared", int'(bus.cleared), 2);
    chk("col0_column", colcode(0), 'o311111);
    chk("col0_tiles", nz(), 6);
    chk("col0_done_once", done_seen, 1);
    repeat (3) @(posedge clk);
    #1 chk("col0_restart_ignored", int'(bus.busy), 0);
    kick(9, 0);
    finish_run("badx");
    chk("badx_cycles", cyc, 2);
    chk("badx_cleared", int'(bus.cleared), 0);
    chk("badx_writes", wr_seen, 0);
    chk("badx_tiles", nz(), 6);
    fill(1);
    kick(3, 3);
    finish_run("all1");
    chk("all1_cleared", int'(bus.cleared), 64);
    chk("all1_tiles", nz(), 0);
    chk("all1_done_once", done_seen, 1);
    fill(0);
    board[3][2] = 1; board[4][2] = 1; board[4][3] = 1; board[4][4] = 1; board[3][4] = 1;
    for (int i = 0; i < 8; i++) board[i][7] = 4;
    kick(3, 2);
    finish_run("u");
    chk("u_cycles_3pass", cyc, 378);
    chk("u_cleared", int'(bus.cleared), 5);
    chk("u_tiles", nz(), 8);
    chk("u_full_col", colcode(7), 'o44444444);
    col0_board();
    board[1][0] = 0; board[2][0] = 3; board[0][0] = 0;
    kick(3, 0);
    while (cyc < 196) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("grav_busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_cleared", int'(bus.cleared), 0);
    chk("abort_tiles_kept", nz(), 1);
    chk("abort_cell", int'(board[2][0]), 3);
    @(posedge clk);
    #1 chk("abort_idle", int'(bus.busy), 0);
    chk("abort_no_done", done_seen, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/elim_sequencer.md
ELIM_SEQUENCER -- requirements
Module: elim_sequencer

Interface
REQ-001 Parameter: MIN_GROUP, default 2, minimum connected same-colour cells for an elimination to proceed.
REQ-002 Parameter: COLOR_W, default 3, colour code width; code 0 = empty cell.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  elimination request (the cursor logic's if_eliminate level); sampled only in IDLE.
REQ-006 sel_x  input  4  row of the selected cell (0 = top, 7 = bottom).
REQ-007 sel_y  input  4  column of the selected cell (0..7).
REQ-008 rd_x, rd_y  output  3 each  board read address.
REQ-009 rd_color  input  COLOR_W  board cell colour at (rd_x, rd_y), valid combinationally in the same cycle.
REQ-010 wr_en  output  1  board write strobe, committed at posedge clk.
REQ-011 wr_x, wr_y  output  3 each  board write address.
REQ-012 wr_color  output  COLOR_W  board write data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on completion of every accepted request.
REQ-015 cleared  output  7  number of cells removed by the last request; held until the next done.

Function
REQ-016 States SHALL be IDLE, SEED, SCAN, CLEAR, GRAV_RD, GRAV_FILL, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 IDLE + start=1 -> SEED; start during busy SHALL be ignored, not queued.
REQ-018 SEED (1 cycle): latch sel_x/sel_y and seed colour from rd_color; clear the 64-bit mark vector; set mark[seed].
REQ-019 SEED: if sel_x>7, sel_y>7 or seed colour = 0 -> DONE with cleared=0 and no writes.
REQ-020 SCAN: visit one cell per cycle, raster order (x outer, y inner, 0..7); a cell becomes marked when its colour = seed colour and any in-board 4-neighbour mark bit is already set.
REQ-021 Mark updates SHALL be visible to later cells in the same pass; edge cells have no off-board neighbours.
REQ-022 After cell (7,7): if the pass marked no new cell -> evaluate group, else start another pass at (0,0).
REQ-023 Group evaluation: popcount(mark) < MIN_GROUP -> DONE with cleared=0 and no writes; else -> CLEAR.
REQ-024 CLEAR: 64 cycles, raster order, wr_en=1 with wr_color=0 exactly at marked cells.
REQ-025 Gravity SHALL process columns 0..7 in order; tiles fall toward x=7.
REQ-026 GRAV_RD: 8 cycles per column, reading x=7 down to 0; each non-empty cell is written to (wp, col), then wp decrements; wp starts at 7 per column.
REQ-027 GRAV_FILL: write 0 to rows wp down to 0 of the column, one per cycle; skipped if wp wrapped below 0 (full column).
REQ-028 Same-cycle read and write of one cell SHALL write back the identical value.
REQ-029 DONE: cleared <= popcount(mark); done=1.
REQ-030 wr_en SHALL be 0 outside CLEAR, GRAV_RD and GRAV_FILL.
REQ-031 Total cycles start->done SHALL be 2 + 64*passes + 64 + sum over columns of (8 + fill rows) for an eliminating request.

Reset
REQ-032 rst=1 -> state IDLE; busy=0, done=0, wr_en=0, cleared=0; mark vector and counters 0.
REQ-033 rst mid-operation aborts on the next edge; board writes already committed SHALL NOT be undone.
REQ-034 rst has priority over start in the same cycle.

Verification
REQ-035 Board all colour 1, select (3,3) -> cleared=64, final board all 0, done exactly once.
REQ-036 Single isolated colour-2 cell at (4,4), select it -> cleared=0, no wr_en asserted, done 130 cycles after start.
REQ-037 Select an empty cell, or sel_x=9 -> done 2 cycles after start, cleared=0, board unchanged.
REQ-038 Column 0 (top to bottom) = 3,2,2,1,1,1,1,1, select (1,0) -> cleared=2; column 0 becomes 0,0,3,1,1,1,1,1.
REQ-039 U-shaped colour-1 group needing a second SCAN pass (marks reached only upward) -> all group cells cleared, pass count = 3.
REQ-040 start pulse while busy, and rst asserted mid-GRAV_RD -> second start ignored; after rst, IDLE with busy=0 next cycle.
